// File: rtl/masked_memory_if.sv
// Load/store port bundle of masked_memory: one read port, one write port and
// the shared fault status, with requester (master) and memory (slave) views.
interface masked_memory_if;
  // Handshake: r_en/w_en are accepted unconditionally on the rising edge they
  // are sampled (no backpressure). Every accepted read yields exactly one
  // r_valid pulse, in issue order, even when the access faults.
  logic        r_en;
  logic [31:0] r_addr;
  logic [1:0]  r_size;
  logic        r_signed;
  logic [31:0] r_data;
  logic        r_valid;
  logic        w_en;
  logic [31:0] w_addr;
  logic [1:0]  w_size;
  logic [31:0] w_data;
  logic [1:0]  state;
  logic [31:0] err_addr;

  modport master (
    output r_en, r_addr, r_size, r_signed,
    output w_en, w_addr, w_size, w_data,
    input  r_data, r_valid, state, err_addr
  );

  modport slave (
    input  r_en, r_addr, r_size, r_signed,
    input  w_en, w_addr, w_size, w_data,
    output r_data, r_valid, state, err_addr
  );
endinterface

// File: rtl/masked_memory.sv
// Byte-addressed data RAM with byte/half/word access, lane-masked writes,
// sign/zero-extended reads, optional read output register and fault reporting.
module masked_memory #(
  parameter string NAME              = "",
  parameter int    MEMORY_SIZE_WORDS = 1024,
  parameter string INIT_FILE         = "",
  parameter int    ADDR_WIDTH        = $clog2(MEMORY_SIZE_WORDS),
  parameter bit    OUTPUT_REG        = 1'b0
) (
  input logic             clk,
  input logic             rst,
  masked_memory_if.slave  bus
);

  localparam logic [1:0] ST_OK    = 2'b00;
  localparam logic [1:0] ST_SIZE  = 2'b01;
  localparam logic [1:0] ST_OOB   = 2'b10;
  localparam logic [1:0] ST_ALIGN = 2'b11;

  logic [31:0] mem [MEMORY_SIZE_WORDS];

  // Any address bit at or above the word-index range makes addr>>2 exceed the
  // capacity, so one compare covers both out-of-bounds cases.
  function automatic logic [1:0] check_access(input logic [31:0] addr,
                                              input logic [1:0]  size);
    logic [1:0] code;
    if (size == 2'b11)
      code = ST_SIZE;
    else if ((addr >> 2) >= 32'(MEMORY_SIZE_WORDS))
      code = ST_OOB;
    else if ((size == 2'b01 && addr[0]) || (size == 2'b10 && addr[1:0] != 2'b00))
      code = ST_ALIGN;
    else
      code = ST_OK;
    return code;
  endfunction

  logic [1:0]            w_code;
  logic [1:0]            r_code;
  logic [ADDR_WIDTH-1:0] w_idx;
  logic [ADDR_WIDTH-1:0] r_idx;
  logic [3:0]            w_mask;
  logic [31:0]           w_rep;
  logic [31:0]           r_word;
  logic [31:0]           r_shift;
  logic [31:0]           r_ext;
  logic [31:0]           r_result;

  assign w_code = check_access(bus.w_addr, bus.w_size);
  assign r_code = check_access(bus.r_addr, bus.r_size);
  assign w_idx  = bus.w_addr[ADDR_WIDTH+1:2];
  assign r_idx  = bus.r_addr[ADDR_WIDTH+1:2];

  always_comb begin
    w_mask = 4'b1111;
    w_rep  = bus.w_data;
    case (bus.w_size)
      2'b00: begin
        w_mask = 4'b0001 << bus.w_addr[1:0];
        w_rep  = {4{bus.w_data[7:0]}};
      end
      2'b01: begin
        w_mask = 4'b0011 << bus.w_addr[1:0];
        w_rep  = {2{bus.w_data[15:0]}};
      end
      default: begin
        w_mask = 4'b1111;
        w_rep  = bus.w_data;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst && bus.w_en && w_code == ST_OK) begin
      for (int i = 0; i < 4; i++) begin
        if (w_mask[i]) mem[w_idx][8*i +: 8] <= w_rep[8*i +: 8];
      end
    end
  end

  // The read samples mem before the same-edge write lands: read-first.
  always_comb begin
    r_word  = mem[r_idx];
    r_shift = r_word >> {bus.r_addr[1:0], 3'b000};
    r_ext   = r_shift;
    case (bus.r_size)
      2'b00:   r_ext = {{24{bus.r_signed & r_shift[7]}}, r_shift[7:0]};
      2'b01:   r_ext = {{16{bus.r_signed & r_shift[15]}}, r_shift[15:0]};
      default: r_ext = r_shift;
    endcase
    r_result = (r_code == ST_OK) ? r_ext : 32'h0;
  end

  logic        s_valid;
  logic [31:0] s_data;

  always_ff @(posedge clk) begin
    if (rst) begin
      s_valid <= 1'b0;
      s_data  <= 32'h0;
    end else begin
      s_valid <= bus.r_en;
      if (bus.r_en) s_data <= r_result;
    end
  end

  if (OUTPUT_REG) begin : g_out_reg
    logic        o_valid;
    logic [31:0] o_data;

    always_ff @(posedge clk) begin
      if (rst) begin
        o_valid <= 1'b0;
        o_data  <= 32'h0;
      end else begin
        o_valid <= s_valid;
        if (s_valid) o_data <= s_data;
      end
    end

    assign bus.r_valid = o_valid;
    assign bus.r_data  = o_data;
  end else begin : g_no_out_reg
    assign bus.r_valid = s_valid;
    assign bus.r_data  = s_data;
  end

  logic [1:0]  state_q;
  logic [31:0] err_q;

  // A read fault outranks a write fault in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_OK;
      err_q   <= 32'h0;
    end else if (bus.r_en && r_code != ST_OK) begin
      state_q <= r_code;
      err_q   <= bus.r_addr;
    end else if (bus.w_en && w_code != ST_OK) begin
      state_q <= w_code;
      err_q   <= bus.w_addr;
    end else if (bus.r_en || bus.w_en) begin
      state_q <= ST_OK;
    end
  end

  assign bus.state    = state_q;
  assign bus.err_addr = err_q;

endmodule

// File: tb/tb_masked_memory.sv
// Bench for masked_memory: two instances (OUTPUT_REG 0 and 1) see identical
// traffic and are checked against a byte-array reference model.
module tb_masked_memory;

  localparam int WORDS     = 64;
  localparam int MEM_BYTES = 4 * WORDS;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  masked_memory_if bus0();
  masked_memory_if bus1();

  assign bus1.r_en     = bus0.r_en;
  assign bus1.r_addr   = bus0.r_addr;
  assign bus1.r_size   = bus0.r_size;
  assign bus1.r_signed = bus0.r_signed;
  assign bus1.w_en     = bus0.w_en;
  assign bus1.w_addr   = bus0.w_addr;
  assign bus1.w_size   = bus0.w_size;
  assign bus1.w_data   = bus0.w_data;

  masked_memory #(
    .NAME("mem_noreg"), .MEMORY_SIZE_WORDS(WORDS), .INIT_FILE(""),
    .ADDR_WIDTH(6), .OUTPUT_REG(1'b0)
  ) dut0 (.clk(clk), .rst(rst), .bus(bus0));

  masked_memory #(
    .NAME("mem_reg"), .MEMORY_SIZE_WORDS(WORDS), .INIT_FILE(""),
    .ADDR_WIDTH(6), .OUTPUT_REG(1'b1)
  ) dut1 (.clk(clk), .rst(rst), .bus(bus1));

  // Scoreboard state
  logic [31:0] exp_q0[$];
  logic [31:0] exp_q1[$];
  int          due_q0[$];
  int          due_q1[$];
  logic [31:0] last0 = 32'h0;
  logic [31:0] last1 = 32'h0;
  bit          mon_on = 1'b0;
  int          n_checks = 0;
  int          n_fail = 0;

  // Reference model: flat byte array plus the fault status registers
  logic [7:0]  ref_mem [MEM_BYTES];
  logic [1:0]  ref_state = 2'b00;
  logic [31:0] ref_err = 32'h0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [1:0] ref_fault(input logic [31:0] addr, input logic [1:0] size);
    if (size == 2'b11) return 2'b01;
    if (addr >= 32'(MEM_BYTES)) return 2'b10;
    if (size == 2'b01 && (addr % 2) != 0) return 2'b11;
    if (size == 2'b10 && (addr % 4) != 0) return 2'b11;
    return 2'b00;
  endfunction

  function automatic logic [31:0] ref_read(input logic [31:0] addr, input logic [1:0] size,
                                           input logic sgn);
    int          n = 1 << size;
    logic [31:0] v = 32'h0;
    for (int i = 0; i < n; i++) v |= 32'(ref_mem[8'(addr + 32'(i))]) << (8 * i);
    if (sgn && n < 4 && v[8*n-1]) v |= ~((32'h1 << (8 * n)) - 32'h1);
    return v;
  endfunction

  task automatic ref_write(input logic [31:0] addr, input logic [1:0] size, input logic [31:0] data);
    int n = 1 << size;
    for (int i = 0; i < n; i++) ref_mem[8'(addr + 32'(i))] = 8'(data >> (8 * i));
  endtask

  task automatic mon_port(input int d, input logic v, input logic [31:0] data);
    logic [31:0] e;
    int          due;
    if (v === 1'b1) begin
      if ((d == 0 && exp_q0.size() == 0) || (d == 1 && exp_q1.size() == 0)) begin
        n_checks++;
        n_fail++;
        $display("FAIL r_valid_unexpected dut%0d: r_valid=1 r_data=%08h, required no pulse (cycle %0d)",
                 d, data, cyc);
      end else begin
        if (d == 0) begin
          e = exp_q0.pop_front(); due = due_q0.pop_front(); last0 = e;
        end else begin
          e = exp_q1.pop_front(); due = due_q1.pop_front(); last1 = e;
        end
        check($sformatf("r_data dut%0d", d), data, e);
        check($sformatf("r_latency dut%0d", d), 32'(cyc), 32'(due));
      end
    end else begin
      check($sformatf("r_valid_low dut%0d", d), {31'h0, v}, 32'h0);
      check($sformatf("r_data_hold dut%0d", d), data, (d == 0) ? last0 : last1);
    end
  endtask

  always @(negedge clk) begin
    if (mon_on) begin
      mon_port(0, bus0.r_valid, bus0.r_data);
      mon_port(1, bus1.r_valid, bus1.r_data);
    end
  end

  // One clock of stimulus; called at posedge+1, returns at the next posedge+1.
  task automatic drive(input logic rs, input logic re, input logic [31:0] ra, input logic [1:0] rsz,
                       input logic rsg, input logic we, input logic [31:0] wa,
                       input logic [1:0] wsz, input logic [31:0] wd);
    logic [1:0]  rc;
    logic [1:0]  wc;
    logic [31:0] rv;
    rst = rs;
    bus0.r_en = re; bus0.r_addr = ra; bus0.r_size = rsz; bus0.r_signed = rsg;
    bus0.w_en = we; bus0.w_addr = wa; bus0.w_size = wsz; bus0.w_data = wd;
    rc = ref_fault(ra, rsz);
    wc = ref_fault(wa, wsz);
    if (rs) begin
      // Results that would emerge at or after the reset edge are lost.
      while (due_q0.size() > 0 && due_q0[$] >= cyc + 1) begin
        void'(due_q0.pop_back()); void'(exp_q0.pop_back());
      end
      while (due_q1.size() > 0 && due_q1[$] >= cyc + 1) begin
        void'(due_q1.pop_back()); void'(exp_q1.pop_back());
      end
      ref_state = 2'b00;
      ref_err   = 32'h0;
    end else begin
      if (re) begin
        rv = (rc == 2'b00) ? ref_read(ra, rsz, rsg) : 32'h0;
        exp_q0.push_back(rv); due_q0.push_back(cyc + 1);
        exp_q1.push_back(rv); due_q1.push_back(cyc + 2);
      end
      if (we && wc == 2'b00) ref_write(wa, wsz, wd);
      if (re && rc != 2'b00) begin
        ref_state = rc; ref_err = ra;
      end else if (we && wc != 2'b00) begin
        ref_state = wc; ref_err = wa;
      end else if (re || we) begin
        ref_state = 2'b00;
      end
    end
    @(posedge clk);
    #1;
    check("state dut0", {30'h0, bus0.state}, {30'h0, ref_state});
    check("state dut1", {30'h0, bus1.state}, {30'h0, ref_state});
    check("err_addr dut0", bus0.err_addr, ref_err);
    check("err_addr dut1", bus1.err_addr, ref_err);
    if (rs) begin
      last0 = 32'h0;
      last1 = 32'h0;
    end
  endtask

  task automatic wr(input logic [31:0] a, input logic [1:0] sz, input logic [31:0] d);
    drive(1'b0, 1'b0, 32'h0, 2'b10, 1'b0, 1'b1, a, sz, d);
  endtask

  task automatic rd(input logic [31:0] a, input logic [1:0] sz, input logic sg);
    drive(1'b0, 1'b1, a, sz, sg, 1'b0, 32'h0, 2'b10, 32'h0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 32'h0, 2'b10, 1'b0, 1'b0, 32'h0, 2'b10, 32'h0);
  endtask

  function automatic logic [31:0] rand_addr(input logic [1:0] sz);
    int unsigned p = $urandom_range(0, 99);
    logic [31:0] base = 32'($urandom_range(0, WORDS - 1)) * 32'd4;
    if (p < 80) begin
      if (sz == 2'b00) return base + 32'($urandom_range(0, 3));
      if (sz == 2'b01) return base + 32'(2 * $urandom_range(0, 1));
      return base;
    end
    if (p < 90) return 32'($urandom_range(0, MEM_BYTES - 1));
    if (p < 95) return 32'(MEM_BYTES) + 32'($urandom_range(0, 64));
    return $urandom;
  endfunction

  function automatic logic [1:0] rand_size();
    if ($urandom_range(0, 99) < 5) return 2'b11;
    return 2'($urandom_range(0, 2));
  endfunction

  initial begin
    rst = 1'b1;
    bus0.r_en = 1'b0; bus0.r_addr = 32'h0; bus0.r_size = 2'b10; bus0.r_signed = 1'b0;
    bus0.w_en = 1'b0; bus0.w_addr = 32'h0; bus0.w_size = 2'b10; bus0.w_data = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    check("reset r_valid dut0", {31'h0, bus0.r_valid}, 32'h0);
    check("reset r_valid dut1", {31'h0, bus1.r_valid}, 32'h0);
    check("reset r_data dut0", bus0.r_data, 32'h0);
    check("reset r_data dut1", bus1.r_data, 32'h0);
    check("reset state dut0", {30'h0, bus0.state}, 32'h0);
    check("reset err_addr dut1", bus1.err_addr, 32'h0);
    mon_on = 1'b1;

    // Give the whole array known contents (first access in the rst-release cycle).
    for (int i = 0; i < WORDS; i++) wr(32'(4 * i), 2'b10, $urandom);

    // Sub-word reads with extension
    wr(32'h10, 2'b10, 32'hDEADBEEF);
    rd(32'h13, 2'b00, 1'b1);
    rd(32'h13, 2'b00, 1'b0);
    rd(32'h10, 2'b01, 1'b1);
    rd(32'h12, 2'b01, 1'b0);
    // Byte-lane masked write
    wr(32'h11, 2'b00, 32'hFFFFFF55);
    rd(32'h10, 2'b10, 1'b0);
    wr(32'h16, 2'b01, 32'h0000A5C3);
    rd(32'h14, 2'b10, 1'b1);
    // Same-cycle read/write to one word is read-first
    wr(32'h20, 2'b10, 32'h0);
    drive(1'b0, 1'b1, 32'h20, 2'b10, 1'b0, 1'b1, 32'h20, 2'b10, 32'h12345678);
    rd(32'h20, 2'b10, 1'b0);
    // Faults
    rd(32'h21, 2'b01, 1'b0);
    idle(1);
    wr(32'(4 * WORDS), 2'b10, 32'hA5A5A5A5);
    rd(32'h0, 2'b10, 1'b0);
    rd(32'h10, 2'b11, 1'b0);
    wr(32'h8000_0010, 2'b00, 32'h77);
    rd(32'h10, 2'b10, 1'b0);
    drive(1'b0, 1'b1, 32'h22, 2'b10, 1'b0, 1'b1, 32'h101, 2'b01, 32'h1);
    drive(1'b0, 1'b1, 32'h24, 2'b10, 1'b0, 1'b1, 32'h101, 2'b01, 32'h1);
    // Back-to-back reads
    rd(32'h0, 2'b10, 1'b0);
    rd(32'h4, 2'b10, 1'b0);
    rd(32'h8, 2'b10, 1'b0);
    idle(3);
    // Reset with a read in flight and a coincident write
    rd(32'h10, 2'b10, 1'b0);
    drive(1'b1, 1'b1, 32'h10, 2'b10, 1'b0, 1'b1, 32'h10, 2'b10, 32'hCAFEF00D);
    rd(32'h10, 2'b10, 1'b0);
    idle(3);

    // Randomised traffic
    for (int i = 0; i < 700; i++) begin
      logic [1:0] rsz;
      logic [1:0] wsz;
      rsz = rand_size();
      wsz = rand_size();
      drive(($urandom_range(0, 99) < 2), ($urandom_range(0, 99) < 70), rand_addr(rsz), rsz,
            1'($urandom_range(0, 1)), ($urandom_range(0, 99) < 60), rand_addr(wsz), wsz, $urandom);
    end

    idle(4);
    check("drained dut0", 32'(exp_q0.size()), 32'h0);
    check("drained dut1", 32'(exp_q1.size()), 32'h0);
    mon_on = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
